// File: rtl/word_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : word_fetch_arbiter
// Purpose  : Shares the single read port of the telemetry word store between
//            the frame formers (index 0 = M16 .. N_REQ-1 = M1). Each read
//            request pulse latches an address as a pending request. Pending
//            requests are served round-robin, one memory read at a time. The
//            returned word lands in that requester's holding register with a
//            one-cycle valid strobe.
// Ports    : clk          - system clock (clk100)
//            reset        - asynchronous, active-high reset
//            req_i        - per-requester one-cycle read request pulse
//            req_addr_i   - per-requester word address, slice k = [k*ADDR_W +: ADDR_W]
//            ovr_clr_i    - clears all overrun_o bits
//            mem_rd_o     - read strobe to the word store
//            mem_addr_o   - read address, qualified by mem_rd_o
//            mem_data_i   - read data, valid RD_LAT cycles after mem_rd_o
//            word_o       - per-requester returned-word holding registers
//            word_valid_o - one-cycle strobe: slice k of word_o just updated
//            overrun_o    - sticky: request k arrived while k still pending
//            busy_o       - a read is being issued or awaited
// Revision : 1.0 - initial release
// ============================================================================
module word_fetch_arbiter #(
    parameter int N_REQ  = 5,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic                     ovr_clr_i,
    output logic                     mem_rd_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic [DATA_W-1:0]        mem_data_i,
    output logic [N_REQ*DATA_W-1:0]  word_o,
    output logic [N_REQ-1:0]         word_valid_o,
    output logic [N_REQ-1:0]         overrun_o,
    output logic                     busy_o
);

    localparam int c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_CNT_W = $clog2(RD_LAT + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_nextState;
    logic [c_PTR_W-1:0]       r_ptr;
    logic [N_REQ-1:0]         r_pend;
    logic [ADDR_W-1:0]        r_addr [N_REQ];
    logic [c_CNT_W-1:0]       r_cnt;
    logic                     r_memRd;
    logic [ADDR_W-1:0]        r_memAddr;
    logic [N_REQ*DATA_W-1:0]  r_word;
    logic [N_REQ-1:0]         r_wordValid;
    logic [N_REQ-1:0]         r_overrun;

    logic                     w_grantValid;
    logic [c_PTR_W-1:0]       w_grantIdx;
    logic [N_REQ-1:0]         w_grantVec;
    logic                     w_capture;
    logic [N_REQ-1:0]         w_ovrSet;

    // Round-robin search: first pending index strictly after r_ptr, wrapping.
    // r_ptr itself is visited last, so the last-served requester has lowest
    // priority on the next grant.
    always_comb begin
        int cand;
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        cand         = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(r_ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!w_grantValid && r_pend[c_PTR_W'(cand)]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = c_PTR_W'(cand);
            end
        end
    end

    // Next-state logic and per-cycle control decodes.
    always_comb begin
        w_nextState = r_state;
        w_grantVec  = '0;
        w_capture   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_grantValid) begin
                    w_grantVec[w_grantIdx] = 1'b1;
                    w_nextState            = c_ISSUE;
                end
            end
            c_ISSUE: begin
                w_nextState = c_WAIT;
            end
            c_WAIT: begin
                // r_cnt is 1 in the first WAIT cycle, so it equals RD_LAT in
                // the cycle whose closing edge sees valid read data.
                if (r_cnt == c_CNT_W'(RD_LAT)) begin
                    w_capture   = 1'b1;
                    w_nextState = c_IDLE;
                end
            end
            default: begin
                w_nextState = c_IDLE;
            end
        endcase
    end

    // A repeat request only counts as an overrun when the old address is not
    // being consumed by a grant on the same edge.
    always_comb begin
        w_ovrSet = req_i & r_pend & ~w_grantVec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= c_PTR_W'(N_REQ - 1);
            r_pend      <= '0;
            r_cnt       <= '0;
            r_memRd     <= 1'b0;
            r_memAddr   <= '0;
            r_word      <= '0;
            r_wordValid <= '0;
            r_overrun   <= '0;
            for (int k = 0; k < N_REQ; k++) begin
                r_addr[k] <= '0;
            end
        end else begin
            r_wordValid <= '0;

            case (r_state)
                c_IDLE: begin
                    if (w_grantValid) begin
                        r_ptr     <= w_grantIdx;
                        r_memAddr <= r_addr[w_grantIdx];
                        r_memRd   <= 1'b1;
                    end
                end
                c_ISSUE: begin
                    r_memRd <= 1'b0;
                    r_cnt   <= c_CNT_W'(1);
                end
                c_WAIT: begin
                    if (w_capture) begin
                        // r_ptr still names the requester granted for this slot.
                        r_word[int'(r_ptr)*DATA_W +: DATA_W] <= mem_data_i;
                        r_wordValid[r_ptr]                   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_memRd <= 1'b0;
                end
            endcase

            // A new request always wins over the grant clearing the pend bit:
            // the grant has already taken the old address above.
            for (int k = 0; k < N_REQ; k++) begin
                if (req_i[k]) begin
                    r_pend[k] <= 1'b1;
                    r_addr[k] <= req_addr_i[k*ADDR_W +: ADDR_W];
                end else if (w_grantVec[k]) begin
                    r_pend[k] <= 1'b0;
                end
            end

            r_overrun <= w_ovrSet | (ovr_clr_i ? '0 : r_overrun);
        end
    end

    assign mem_rd_o     = r_memRd;
    assign mem_addr_o   = r_memAddr;
    assign word_o       = r_word;
    assign word_valid_o = r_wordValid;
    assign overrun_o    = r_overrun;
    assign busy_o       = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_word_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_fetch_arbiter
// Purpose  : Self-checking bench for word_fetch_arbiter. A memory model
//            returns addr ^ 0xA5A two cycles after each read strobe; expected
//            reads and returned words are queued when requests are driven and
//            popped when the DUT issues reads and raises valid strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_fetch_arbiter;

    localparam int N_REQ  = 5;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 12;
    localparam int RD_LAT = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N_REQ-1:0]         req_i;
    logic [N_REQ*ADDR_W-1:0]  req_addr_i;
    logic                     ovr_clr_i;
    logic                     mem_rd_o;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic [DATA_W-1:0]        mem_data_i;
    logic [N_REQ*DATA_W-1:0]  word_o;
    logic [N_REQ-1:0]         word_valid_o;
    logic [N_REQ-1:0]         overrun_o;
    logic                     busy_o;

    word_fetch_arbiter #(
        .N_REQ (N_REQ),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .req_addr_i  (req_addr_i),
        .ovr_clr_i   (ovr_clr_i),
        .mem_rd_o    (mem_rd_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i),
        .word_o      (word_o),
        .word_valid_o(word_valid_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  idx;
        logic [10:0] addr;
    } exp_t;

    typedef struct packed {
        logic [4:0]  req;
        logic [14:0] ord;   // expected grant order, entry j at [j*3 +: 3]
        logic [2:0]  nOrd;
    } vec_t;

    exp_t               rdQ[$];
    exp_t               wvQ[$];
    int                 rdCycQ[$];
    int                 rdLog[$];
    int                 cyc     = 0;
    int                 nChecks = 0;
    int                 nFails  = 0;
    logic [59:0]        shadow  = '0;
    exp_t               me;
    logic [11:0]        dl1;
    vec_t               vecs [8];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data for a read seen in cycle c is valid during cycle c+2.
    always @(posedge clk) begin
        dl1        <= mem_rd_o ? (12'(mem_addr_o) ^ 12'hA5A) : 12'($urandom);
        mem_data_i <= dl1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        nChecks++;
        nFails++;
        $display("FAIL %s: got 0x%0h, required nothing (cycle %0d)", name, act, cyc);
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rd_o) begin
                rdLog.push_back(cyc);
                rdCycQ.push_back(cyc);
                if (rdQ.size() == 0) begin
                    flag("unexpected_read", 64'(mem_addr_o));
                end else begin
                    me = rdQ.pop_front();
                    check("rd_addr", 64'(mem_addr_o), 64'(me.addr));
                end
            end
            if (word_valid_o != '0) begin
                if (wvQ.size() == 0) begin
                    flag("unexpected_valid", 64'(word_valid_o));
                end else begin
                    me = wvQ.pop_front();
                    check("valid_onehot", 64'(word_valid_o), 64'(5'b00001 << me.idx));
                    check("word_slice", 64'(word_o[me.idx*12 +: 12]), 64'(12'(me.addr) ^ 12'hA5A));
                    shadow[me.idx*12 +: 12] = 12'(me.addr) ^ 12'hA5A;
                    check("word_hold", 64'(word_o), 64'(shadow));
                    if (rdCycQ.size() > 0) begin
                        check("latency", 64'(cyc - rdCycQ.pop_front()), 64'(RD_LAT + 1));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input int idx, input logic [10:0] addr);
        exp_t e;
        e.idx  = 3'(idx);
        e.addr = addr;
        rdQ.push_back(e);
        wvQ.push_back(e);
    endtask

    task automatic pulse(input logic [4:0] r, input logic [54:0] a);
        req_i      = r;
        req_addr_i = a;
        tick();
        req_i      = '0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            tick();
            if (rdQ.size() == 0 && wvQ.size() == 0 && !busy_o) done = 1'b1;
        end
        if (!done) flag("drain_timeout", 64'(rdQ.size() + wvQ.size()));
        repeat (3) tick();
    endtask

    task automatic waitValid(input int k);
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            tick();
            if (word_valid_o[k]) seen = 1'b1;
        end
        if (!seen) flag("valid_timeout", 64'(k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        logic [54:0] a;
        logic [2:0]  o;
        int          t0;

        vecs[0] = '{req: 5'b10000, ord: {12'd0, 3'd4},                     nOrd: 3'd1};
        vecs[1] = '{req: 5'b11111, ord: {3'd4, 3'd3, 3'd2, 3'd1, 3'd0},    nOrd: 3'd5};
        vecs[2] = '{req: 5'b10100, ord: {9'd0, 3'd4, 3'd2},                nOrd: 3'd2};
        vecs[3] = '{req: 5'b01011, ord: {6'd0, 3'd3, 3'd1, 3'd0},          nOrd: 3'd3};
        vecs[4] = '{req: 5'b10001, ord: {9'd0, 3'd0, 3'd4},                nOrd: 3'd2};
        vecs[5] = '{req: 5'b00110, ord: {9'd0, 3'd2, 3'd1},                nOrd: 3'd2};
        vecs[6] = '{req: 5'b00011, ord: {9'd0, 3'd1, 3'd0},                nOrd: 3'd2};
        vecs[7] = '{req: 5'b01000, ord: {12'd0, 3'd3},                     nOrd: 3'd1};

        reset      = 1'b1;
        req_i      = '0;
        req_addr_i = '0;
        ovr_clr_i  = 1'b0;

        // Reset state
        repeat (3) begin
            tick();
            check("reset_ctrl", 64'({mem_rd_o, mem_addr_o, word_valid_o, overrun_o, busy_o}), 64'd0);
            check("reset_word", 64'(word_o), 64'd0);
        end
        reset = 1'b0;
        tick();
        check("post_reset_ctrl", 64'({mem_rd_o, mem_addr_o, word_valid_o, overrun_o, busy_o}), 64'd0);

        // Single request from idle: read two cycles later, word three after that.
        rdLog.delete();
        pushExp(0, 11'h155);
        t0 = cyc;
        pulse(5'b00001, 55'(11'h155));
        drain();
        if (rdLog.size() > 0) check("first_rd_cycle", 64'(rdLog[0] - t0), 64'd2);
        else flag("first_rd_missing", 64'd0);
        check("first_word", 64'(word_o[11:0]), 64'(12'h155 ^ 12'hA5A));

        // Table-driven simultaneous request patterns; each slot is RD_LAT+2.
        for (int i = 0; i < 8; i++) begin
            a = '0;
            for (int k = 0; k < N_REQ; k++) a[k*11 +: 11] = 11'((i * 97 + k * 211 + 5) % 2048);
            for (int j = 0; j < int'(vecs[i].nOrd); j++) begin
                o = vecs[i].ord[j*3 +: 3];
                pushExp(int'(o), a[o*11 +: 11]);
            end
            rdLog.delete();
            pulse(vecs[i].req, a);
            drain();
            check("vec_reads", 64'(rdLog.size()), 64'(vecs[i].nOrd));
            for (int j = 1; j < rdLog.size(); j++) begin
                check("vec_spacing", 64'(rdLog[j] - rdLog[j-1]), 64'(RD_LAT + 2));
            end
        end
        check("no_overrun_after_table", 64'(overrun_o), 64'd0);

        // Fairness: requester 0 re-requests after every valid, 3 asks once.
        pushExp(0, 11'h0A1);
        pulse(5'b00001, 55'(11'h0A1));
        pushExp(3, 11'h3B3);
        pulse(5'b01000, 55'(11'h3B3) << 33);
        waitValid(0);
        pushExp(0, 11'h0C1);
        pulse(5'b00001, 55'(11'h0C1));
        waitValid(0);
        pushExp(0, 11'h0C2);
        pulse(5'b00001, 55'(11'h0C2));
        drain();

        // Overrun: second request while still pending replaces the address.
        pushExp(0, 11'h044);
        pulse(5'b00001, 55'(11'h044));
        pulse(5'b00100, 55'(11'h010) << 22);
        pushExp(2, 11'h020);
        pulse(5'b00100, 55'(11'h020) << 22);
        drain();
        check("overrun_set", 64'(overrun_o), 64'(5'b00100));
        ovr_clr_i = 1'b1;
        tick();
        ovr_clr_i = 1'b0;
        check("overrun_clear", 64'(overrun_o), 64'd0);

        // Overrun coinciding with clear: the set wins.
        pushExp(0, 11'h055);
        pulse(5'b00001, 55'(11'h055));
        pulse(5'b00100, 55'(11'h0F0) << 22);
        pushExp(2, 11'h0E0);
        ovr_clr_i = 1'b1;
        pulse(5'b00100, 55'(11'h0E0) << 22);
        ovr_clr_i = 1'b0;
        drain();
        check("overrun_set_wins", 64'(overrun_o), 64'(5'b00100));
        ovr_clr_i = 1'b1;
        tick();
        ovr_clr_i = 1'b0;
        check("overrun_clear2", 64'(overrun_o), 64'd0);

        // Re-request in the grant cycle: old address read, new one follows.
        pushExp(1, 11'h111);
        pulse(5'b00010, 55'(11'h111) << 11);
        pushExp(1, 11'h122);
        pulse(5'b00010, 55'(11'h122) << 11);
        drain();
        check("coincident_no_overrun", 64'(overrun_o), 64'd0);

        // Reset during WAIT discards the read and the other pending request.
        pushExp(0, 11'h2AA);
        pulse(5'b00001, 55'(11'h2AA));
        pulse(5'b00100, 55'(11'h233) << 22);
        tick();
        reset = 1'b1;
        rdQ.delete();
        wvQ.delete();
        rdCycQ.delete();
        shadow = '0;
        tick();
        check("mid_reset_ctrl", 64'({mem_rd_o, word_valid_o, busy_o}), 64'd0);
        tick();
        reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            check("post_reset_quiet", 64'({mem_rd_o, word_valid_o, busy_o}), 64'd0);
        end
        check("post_reset_word", 64'(word_o), 64'd0);
        a = '0;
        a[0*11 +: 11] = 11'h301;
        a[3*11 +: 11] = 11'h3CC;
        pushExp(0, 11'h301);
        pushExp(3, 11'h3CC);
        pulse(5'b01001, a);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
